multi_flow_gen: RTL
===================

# multi_flow_gen

Parametrised multi-flow C2H traffic generator that drives one AXI-Stream C2H port toward the QDMA from NUM_FLOWS independent flows. It is the successor to the single-flow generator. Each flow has its own packet budget, per-flow descriptor credit counter and inter-packet gap rate limiter. A round-robin arbiter picks among eligible flows, and each packet is tagged with its flow id.

## Interface
Parameters:
- C_DATA_WIDTH, 512, stream data width in bits (multiple of 8)
- NUM_FLOWS, 4, number of flows (2..16)
- TM_DSC_BITS, 16, credit counter width
- FLOW_W, $clog2(NUM_FLOWS), flow id width

Ports:
- axi_aclk  in  1  clock
- user_reset  in  1  reset, asynchronous, active-high
- control_reg  in  32  bit1 = run; other bits ignored
- flow_en  in  NUM_FLOWS  per-flow enable, sampled at run start
- txr_size  in  16  packet length in bytes, common to all flows
- num_pkt  in  NUM_FLOWS*16  per-flow packet budget, flow i at [16i+15:16i]
- gap_cycles  in  NUM_FLOWS*32  per-flow minimum cycles between packet starts
- credit_perpkt_in  in  TM_DSC_BITS  descriptor credits consumed per packet
- credit_in  in  TM_DSC_BITS  credit amount to add
- credit_flow  in  FLOW_W  target flow for credit_in
- credit_updt  in  1  one-cycle strobe that adds credit_in to credit_flow
- c2h_tdata  out  C_DATA_WIDTH  payload
- c2h_dpar  out  C_DATA_WIDTH/8  per-byte even parity
- c2h_tvalid  out  1  beat valid
- c2h_tlast  out  1  last beat of packet
- c2h_qid  out  FLOW_W  flow id of current packet
- c2h_tready  in  1  sink ready
- c2h_end  out  1  one-cycle pulse when all enabled flows are finished

## Operation
- FSM states: IDLE, ARB, SEND, DONE.
- IDLE:
  - On run=1: latch remaining[i] = flow_en[i] ? num_pkt[i] : 0 and clear gap counters.
  - If every remaining[i] is 0: go to DONE and pulse c2h_end. Otherwise go to ARB.
- Eligibility: flow i is eligible when remaining[i] != 0, credit[i] >= credit_perpkt_in and gap[i] == 0.
- ARB:
  - run=0: go to IDLE.
  - No flow eligible: stay in ARB.
  - Otherwise grant the first eligible flow after last_grant, round-robin with wrap.
  - On grant: latch qid, credit[qid] -= credit_perpkt_in, remaining[qid] -= 1, gap[qid] = gap_cycles[qid], beat counter = 0. Go to SEND.
- SEND:
  - Beats per packet = max(1, ceil(txr_size / (C_DATA_WIDTH/8))). txr_size=0 sends 1 beat.
  - tdata = {qid, 16-bit packet sequence number of that flow, 16-bit beat index}, zero-extended to C_DATA_WIDTH.
  - dpar[k] = ^tdata[8k+7:8k].
  - tlast is asserted on the final beat.
  - When the tlast beat is accepted:
    - All remaining are 0: go to DONE and pulse c2h_end.
    - Else run=1: go to ARB.
    - Else: go to IDLE.
- Deasserting run never truncates a packet.
- DONE: hold until run=0, then go to IDLE.
- Credits:
  - Counters are saturating and cleared only by reset; they persist across runs.
  - credit_updt to flow q in the same cycle as a grant of flow q: the net value is applied, old + credit_in − perpkt, saturating at max.
- Gap counters decrement every cycle in every state and stop at 0.

## Timing
- Reset values: all outputs 0, state IDLE, credits 0, remaining 0, last_grant = NUM_FLOWS-1 (first grant goes to flow 0).
- Run start to first tvalid: 2 cycles (IDLE→ARB, ARB→SEND), provided a flow is eligible.
- tvalid is registered.
- Between packets there is one ARB bubble cycle, so there are never back-to-back tlast→tvalid beats in consecutive cycles.
- AXIS rule: while tvalid=1 and tready=0, tdata, tlast, qid and dpar are held stable. A beat advances only when tvalid && tready.
- user_reset mid-packet: tvalid drops asynchronously and the FSM returns to IDLE.
- c2h_end is high for exactly one cycle per run.

## Structure
- Package multi_flow_pkg holds:
  - the state enum
  - function beats_for(size, width)
  - function byte_parity
  - the credit saturating-add/subtract helper
- Sub-module flow_rr_arbiter (NUM_FLOWS request in, one-hot and binary grant out, last_grant pointer) is instantiated once.

## Test plan
- NUM_FLOWS=4, all enabled, num_pkt=2 each, credits=32 each, perpkt=1, gap=0, txr_size=4096, tready=1 → 8 packets of 64 beats, qid order 0,1,2,3,0,1,2,3, then c2h_end pulses once.
- Flow 1 has 0 credits and the others have 32 → no qid=1 packets. credit_updt(flow 1, 4) mid-run → flow 1 is served in its next round-robin slot.
- gap_cycles[0]=1000 and flow 0 the only flow enabled, num_pkt=3 → packet starts ≥1000 cycles apart.
- Random tready toggling with txr_size=100 (2 beats) → payload and dpar stable while stalled, beat index sequence 0,1, and tlast on beat 1.
- run deasserted in the middle of beat 10 of 64 → the packet completes to tlast, then FSM is IDLE with no further tvalid.
- Simultaneous credit_updt and grant on flow 2 with credit 5 → 5 + credit_in − perpkt. Saturation at 16'hFFFF verified.

Source files
------------

// File: rtl/multi_flow_gen_pkg.sv
// Shared types and helpers for the multi-flow C2H traffic generator.
package multi_flow_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARB  = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } state_t;

   // Beats needed to carry `size` bytes on a `width`-bit bus; an empty packet still takes one beat.
   function automatic logic [15:0] beats_for(input logic [15:0] size, input int unsigned width);
      int unsigned bytes;
      int unsigned n;
      bytes = width / 8;
      n = (32'(size) + bytes - 1) / bytes;
      if (n == 0) n = 1;
      return n[15:0];
   endfunction

   // Even parity of one byte.
   function automatic logic byte_parity(input logic [7:0] b);
      return ^b;
   endfunction

   // Credit counter update: optional add, optional subtract, net result clamped to a `bits`-wide maximum.
   // A subtract is only requested when old >= sub, so the net never goes negative.
   function automatic logic [31:0] credit_sat(input logic [31:0] old,
                                              input logic [31:0] add,
                                              input logic [31:0] sub,
                                              input logic        add_en,
                                              input logic        sub_en,
                                              input int unsigned bits);
      logic [33:0] acc;
      logic [33:0] lim;
      acc = {2'b00, old};
      if (add_en) acc = acc + {2'b00, add};
      if (sub_en) acc = acc - {2'b00, sub};
      lim = (34'd1 << bits) - 34'd1;
      if (acc > lim) acc = lim;
      return acc[31:0];
   endfunction

endpackage

// File: rtl/multi_flow_gen_if.sv
// AXI-Stream C2H port carrying tagged packets toward the QDMA.
interface multi_flow_gen_if #(
   parameter int C_DATA_WIDTH = 512,
   parameter int FLOW_W       = 2
);
   logic [C_DATA_WIDTH-1:0]   tdata;
   logic [C_DATA_WIDTH/8-1:0] dpar;
   logic                      tvalid;
   logic                      tlast;
   logic [FLOW_W-1:0]         qid;
   logic                      tready;

   modport master (output tdata, dpar, tvalid, tlast, qid, input tready);
   modport slave  (input tdata, dpar, tvalid, tlast, qid, output tready);
endinterface

// File: rtl/multi_flow_gen_flow_rr_arbiter.sv
// Round-robin arbiter over the flow request vector; searches starting just after the last granted flow.
module flow_rr_arbiter #(
   parameter int NUM_FLOWS = 4,
   parameter int FLOW_W    = $clog2(NUM_FLOWS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_FLOWS-1:0] req,
   input  logic                 take,
   output logic [NUM_FLOWS-1:0] gnt_oh,
   output logic [FLOW_W-1:0]    gnt_id,
   output logic                 gnt_vld,
   output logic [FLOW_W-1:0]    last_grant
);

   logic [FLOW_W-1:0] idx;

   // First requesting flow after last_grant, wrapping around the flow set.
   always_comb begin
      gnt_oh  = '0;
      gnt_id  = '0;
      gnt_vld = 1'b0;
      idx     = '0;
      for (int off = 1; off <= NUM_FLOWS; off++) begin
         idx = FLOW_W'((32'(last_grant) + 32'(off)) % 32'(NUM_FLOWS));
         if (!gnt_vld && req[idx]) begin
            gnt_vld     = 1'b1;
            gnt_oh[idx] = 1'b1;
            gnt_id      = idx;
         end
      end
   end

   // Pointer starts at the highest flow so the very first grant lands on flow 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_grant <= FLOW_W'(NUM_FLOWS - 1);
      else if (take && gnt_vld)
         last_grant <= gnt_id;
   end

endmodule

// File: rtl/multi_flow_gen.sv
// Multi-flow C2H traffic generator: per-flow budget, credits and gap limiter, round-robin
// packet scheduling onto one AXI-Stream port, every packet tagged with its flow id.
module multi_flow_gen
   import multi_flow_pkg::*;
#(
   parameter int C_DATA_WIDTH = 512,
   parameter int NUM_FLOWS    = 4,
   parameter int TM_DSC_BITS  = 16,
   parameter int FLOW_W       = $clog2(NUM_FLOWS)
) (
   input  logic                      axi_aclk,
   input  logic                      user_reset,
   input  logic [31:0]               control_reg,
   input  logic [NUM_FLOWS-1:0]      flow_en,
   input  logic [15:0]               txr_size,
   input  logic [NUM_FLOWS*16-1:0]   num_pkt,
   input  logic [NUM_FLOWS*32-1:0]   gap_cycles,
   input  logic [TM_DSC_BITS-1:0]    credit_perpkt_in,
   input  logic [TM_DSC_BITS-1:0]    credit_in,
   input  logic [FLOW_W-1:0]         credit_flow,
   input  logic                      credit_updt,
   multi_flow_gen_if.master          c2h,
   output logic                      c2h_end
);

   localparam int BYTES = C_DATA_WIDTH / 8;

   state_t                                 state;
   logic                                   run;
   logic [NUM_FLOWS-1:0][15:0]             remaining;
   logic [NUM_FLOWS-1:0][15:0]             seq_cnt;
   logic [NUM_FLOWS-1:0][TM_DSC_BITS-1:0]  credit;
   logic [NUM_FLOWS-1:0][31:0]             gap;
   logic [NUM_FLOWS-1:0]                   req;
   logic [NUM_FLOWS-1:0]                   gnt_oh;
   logic [FLOW_W-1:0]                      gnt_id;
   logic [FLOW_W-1:0]                      last_grant;
   logic                                   gnt_vld;
   logic                                   grant;
   logic                                   start;
   logic                                   start_empty;
   logic                                   all_done;
   logic [15:0]                            nbeats;
   logic [15:0]                            nbeats_q;
   logic [15:0]                            beat_q;
   logic [15:0]                            seq_q;
   logic [FLOW_W-1:0]                      qid_q;
   logic                                   tvalid_q;
   logic                                   tlast_q;
   logic [C_DATA_WIDTH-1:0]                tdata_w;
   logic [BYTES-1:0]                       dpar_w;
   logic                                   unused_ok;

   assign run    = control_reg[1];
   assign start  = (state == IDLE) && run;
   assign grant  = (state == ARB) && run && gnt_vld;
   assign nbeats = beats_for(txr_size, C_DATA_WIDTH);
   assign unused_ok = ^{control_reg[31:2], control_reg[0], gnt_oh, last_grant};

   // Eligibility per flow, plus the "nothing to do" summaries used for the end-of-run pulse.
   always_comb begin
      req         = '0;
      start_empty = 1'b1;
      all_done    = 1'b1;
      for (int i = 0; i < NUM_FLOWS; i++) begin
         req[i] = (remaining[i] != 16'd0) && (credit[i] >= credit_perpkt_in) && (gap[i] == 32'd0);
         if (flow_en[i] && (num_pkt[16*i +: 16] != 16'd0)) start_empty = 1'b0;
         if (remaining[i] != 16'd0) all_done = 1'b0;
      end
   end

   flow_rr_arbiter #(
      .NUM_FLOWS (NUM_FLOWS),
      .FLOW_W    (FLOW_W)
   ) u_arb (
      .clk        (axi_aclk),
      .rst        (user_reset),
      .req        (req),
      .take       (grant),
      .gnt_oh     (gnt_oh),
      .gnt_id     (gnt_id),
      .gnt_vld    (gnt_vld),
      .last_grant (last_grant)
   );

   // Credit counters persist across runs; a refill and a grant on the same flow net together.
   always_ff @(posedge axi_aclk or posedge user_reset) begin
      if (user_reset) begin
         credit <= '0;
      end else begin
         for (int i = 0; i < NUM_FLOWS; i++) begin
            credit[i] <= TM_DSC_BITS'(credit_sat(32'(credit[i]), 32'(credit_in), 32'(credit_perpkt_in),
                                                 credit_updt && (credit_flow == FLOW_W'(i)),
                                                 grant && (gnt_id == FLOW_W'(i)),
                                                 TM_DSC_BITS));
         end
      end
   end

   // Inter-packet gap limiters: reload on grant, cleared at run start, otherwise count down to 0.
   always_ff @(posedge axi_aclk or posedge user_reset) begin
      if (user_reset) begin
         gap <= '0;
      end else begin
         for (int i = 0; i < NUM_FLOWS; i++) begin
            if (start)
               gap[i] <= 32'd0;
            else if (grant && (gnt_id == FLOW_W'(i)))
               gap[i] <= gap_cycles[32*i +: 32];
            else if (gap[i] != 32'd0)
               gap[i] <= gap[i] - 32'd1;
         end
      end
   end

   // Main FSM: run start, arbitration, beat streaming with AXIS hold, end-of-run pulse.
   always_ff @(posedge axi_aclk or posedge user_reset) begin
      if (user_reset) begin
         state     <= IDLE;
         tvalid_q  <= 1'b0;
         tlast_q   <= 1'b0;
         qid_q     <= '0;
         seq_q     <= '0;
         beat_q    <= '0;
         nbeats_q  <= 16'd1;
         remaining <= '0;
         seq_cnt   <= '0;
         c2h_end   <= 1'b0;
      end else begin
         c2h_end <= 1'b0;
         case (state)
            IDLE: begin
               if (run) begin
                  for (int i = 0; i < NUM_FLOWS; i++)
                     remaining[i] <= flow_en[i] ? num_pkt[16*i +: 16] : 16'd0;
                  seq_cnt <= '0;
                  if (start_empty) begin
                     state   <= DONE;
                     c2h_end <= 1'b1;
                  end else begin
                     state <= ARB;
                  end
               end
            end
            ARB: begin
               if (!run) begin
                  state <= IDLE;
               end else if (gnt_vld) begin
                  qid_q              <= gnt_id;
                  seq_q              <= seq_cnt[gnt_id];
                  seq_cnt[gnt_id]    <= seq_cnt[gnt_id] + 16'd1;
                  remaining[gnt_id]  <= remaining[gnt_id] - 16'd1;
                  beat_q             <= 16'd0;
                  nbeats_q           <= nbeats;
                  tvalid_q           <= 1'b1;
                  tlast_q            <= (nbeats == 16'd1);
                  state              <= SEND;
               end
            end
            SEND: begin
               if (tvalid_q && c2h.tready) begin
                  if (tlast_q) begin
                     tvalid_q <= 1'b0;
                     tlast_q  <= 1'b0;
                     if (all_done) begin
                        state   <= DONE;
                        c2h_end <= 1'b1;
                     end else if (run) begin
                        state <= ARB;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     beat_q  <= beat_q + 16'd1;
                     tlast_q <= ((beat_q + 16'd2) == nbeats_q);
                  end
               end
            end
            DONE: begin
               if (!run) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Payload is a pure function of held registers, so it stays stable through back-pressure.
   always_comb begin
      tdata_w              = '0;
      tdata_w[15:0]        = beat_q;
      tdata_w[31:16]       = seq_q;
      tdata_w[32 +: FLOW_W] = qid_q;
   end

   // Per-byte even parity of the outgoing payload.
   always_comb begin
      dpar_w = '0;
      for (int k = 0; k < BYTES; k++)
         dpar_w[k] = byte_parity(tdata_w[8*k +: 8]);
   end

   assign c2h.tdata  = tdata_w;
   assign c2h.dpar   = dpar_w;
   assign c2h.tvalid = tvalid_q;
   assign c2h.tlast  = tlast_q;
   assign c2h.qid    = qid_q;

endmodule
